gray4_step_ctrl: RTL and testbench
==================================

# gray4_step_ctrl

Run controller for the lab 4-bit Gray-code counter. It holds the Gray count state, generates the count-enable strobe from a programmable prescaler, and runs the count either for a programmed number of steps (one-shot) or continuously until stopped. It sits between the board-level control inputs (buttons/switches) and the display/cascade logic, replacing free-running ce generation in the Gray counter labs.

## Interface
- PRESC_W, 8, width of the prescaler divide value `div`.
- clk  in  1  system clock; all state changes on the rising edge.
- rn  in  1  synchronous active-low reset, sampled on the rising edge of clk; overrides every other input.
- start  in  1  level, sampled in IDLE only; begins a run.
- stop  in  1  level, sampled in RUN only; aborts a run.
- mode  in  1  0 = one-shot (nsteps steps), 1 = continuous; latched at start.
- cl  in  1  1 at start clears the count to 0000 before running; 0 resumes from the held Y.
- div  in  PRESC_W  step period minus one, in clk cycles; latched at start.
- nsteps  in  4  one-shot step count; 0 means 16; latched at start.
- Y  out  4  Gray-coded count, registered.
- ce_o  out  1  step strobe, high for the one cycle at whose closing edge Y advances.
- TC  out  1  terminal count: Y == 1000 (binary 15); combinational from Y.
- CEO  out  1  ce_o & TC; cascade carry strobe.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal one-shot completion.

## Operation
- Internal state: binary count `b[3:0]`; Y = b ^ (b >> 1), registered together with b.
- Gray sequence from 0000: 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then wraps to 0000.
- States:
  - IDLE: start=1 → RUN. Latch mode, div and nsteps; load steps_left (nsteps, or 16 if 0); presc = 0; if cl=1, b = 0. stop is ignored in IDLE.
  - RUN: presc counts 0..div_latched.
    - Step condition: presc == div_latched and stop=0. Drive ce_o = 1, b ← b+1 mod 16, presc ← 0, steps_left ← steps_left − 1.
    - One-shot, step taken with steps_left == 1 → DONE.
    - stop=1 → IDLE immediately. No step that cycle, ce_o suppressed, done not asserted.
    - start is ignored in RUN.
  - DONE: done = 1 for one cycle, then → IDLE. Inputs are ignored.
- Continuous mode runs indefinitely and wraps 1000 → 0000; steps_left is not used.
- Y holds its value in IDLE and DONE, across runs and after stop.
- div, mode, nsteps and cl changes during RUN have no effect.
- Reset (rn=0 at an edge): state IDLE, b = 0, Y = 0000, presc = 0, steps_left = 0. Outputs: ce_o = 0, TC = 0, CEO = 0, busy = 0, done = 0. Applies mid-run, including a cycle where a step would occur.

## Timing
- start sampled high at edge E0 → busy = 1 in the cycle after E0.
- First ce_o occurs in cycle div after E0, counting the first RUN cycle as cycle 0. Y updates at edge E(div+1).
- Steps then repeat every div+1 cycles; div = 0 steps every cycle.
- One-shot: last Y update at edge En. Then busy = 0 and done = 1 in the cycle after En, followed by IDLE. Earliest restart is start sampled at E(n+2).
- stop sampled at edge Es → busy = 0 in the cycle after Es.
- ce_o, CEO and TC are combinational from registered state and stop; there are no extra latency stages.

## Test plan
- Reset: rn=0 for 2 cycles with start=1 and stop=0 → Y=0000, busy=0, ce_o=0, done=0. After rn=1, the next start starts a run.
- One-shot with div=3, nsteps=5, cl=1 → Y goes 0001, 0011, 0010, 0110, 0111; ce_o is high every 4th cycle; the first update is at E4. done pulses once after the 5th update, busy falls, and Y holds 0111.
- Continuous with div=0, cl=1 → 16 consecutive ce_o walk the full Gray sequence. TC is high while Y=1000, and CEO is high exactly once per 16 steps, coincident with the 1000 → 0000 step. stop then → IDLE with Y held.
- Stop collision: div=2, continuous, stop=1 in a cycle where presc==2 → ce_o=0, Y unchanged, done=0, busy=0 in the next cycle.
- nsteps=0 with cl=0 from Y=0111 → exactly 16 steps, ending at Y=0111 with one done pulse. start asserted during DONE is ignored.
- Mid-run reset: rn=0 on the edge where a step is due → Y=0000, busy=0, no done, ce_o=0 in the next cycle.

Source files
------------

// File: rtl/gray4_step_ctrl.sv
// gray4_step_ctrl
// Run controller for a 4-bit Gray-code counter. Holds the count, derives the
// step strobe from a programmable prescaler, and runs either a programmed
// number of steps (one-shot) or continuously until stopped.
//
// Ports
//   clk     : system clock, all state changes on the rising edge
//   rn      : synchronous active-low reset, overrides every other input
//   start   : begins a run (sampled in IDLE only)
//   stop    : aborts a run (sampled in RUN only)
//   mode    : 0 = one-shot, 1 = continuous (latched at start)
//   cl      : 1 at start clears the count before running
//   div     : step period minus one, in clk cycles (latched at start)
//   nsteps  : one-shot step count, 0 means 16 (latched at start)
//   Y       : registered Gray-coded count
//   ce_o    : step strobe, high in the cycle whose closing edge advances Y
//   TC      : terminal count, Y == 1000
//   CEO     : cascade carry, ce_o & TC
//   busy    : high while running
//   done    : one-cycle pulse on normal one-shot completion
module gray4_step_ctrl #(
    parameter int unsigned PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rn,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic               cl,
    input  logic [PRESC_W-1:0] div,
    input  logic [3:0]         nsteps,
    output logic [3:0]         Y,
    output logic               ce_o,
    output logic               TC,
    output logic               CEO,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_ONE = PRESC_W'(1);

    state_t             r_state;
    logic [3:0]         r_b;
    logic [3:0]         r_y;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_div;
    logic               r_mode;
    // Five bits so that nsteps = 0 can be held as 16.
    logic [4:0]         r_steps_left;

    logic               w_step;
    logic [3:0]         w_b_next;
    logic [3:0]         w_y_next;

    // stop has priority over a due step, so it masks the strobe directly.
    assign w_step   = (r_state == S_RUN) && (r_presc == r_div) && !stop;
    assign w_b_next = r_b + 4'd1;
    assign w_y_next = w_b_next ^ (w_b_next >> 1);

    assign Y    = r_y;
    assign ce_o = w_step;
    assign TC   = (r_y == 4'b1000);
    assign CEO  = w_step && TC;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rn) begin
            r_state      <= S_IDLE;
            r_b          <= '0;
            r_y          <= '0;
            r_presc      <= '0;
            r_div        <= '0;
            r_mode       <= 1'b0;
            r_steps_left <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_mode       <= mode;
                        r_div        <= div;
                        r_steps_left <= (nsteps == 4'd0) ? 5'd16 : {1'b0, nsteps};
                        r_presc      <= '0;
                        if (cl) begin
                            r_b <= '0;
                            r_y <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (w_step) begin
                        r_b     <= w_b_next;
                        r_y     <= w_y_next;
                        r_presc <= '0;
                        if (!r_mode) begin
                            r_steps_left <= r_steps_left - 5'd1;
                            if (r_steps_left == 5'd1) begin
                                r_state <= S_DONE;
                            end
                        end
                    end else begin
                        r_presc <= r_presc + PRESC_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray4_step_ctrl.sv
// Self-checking bench for gray4_step_ctrl. Expected values come from the
// Gray sequence table and run arithmetic (cycle index vs. step period).
module tb_gray4_step_ctrl;

    logic       clk;
    logic       rn;
    logic       start;
    logic       stop;
    logic       mode;
    logic       cl;
    logic [7:0] div;
    logic [3:0] nsteps;
    logic [3:0] Y;
    logic       ce_o;
    logic       TC;
    logic       CEO;
    logic       busy;
    logic       done;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned m_b;   // model: binary count currently held

    logic [3:0] gseq [16];

    gray4_step_ctrl #(.PRESC_W(8)) dut (
        .clk    (clk),
        .rn     (rn),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .cl     (cl),
        .div    (div),
        .nsteps (nsteps),
        .Y      (Y),
        .ce_o   (ce_o),
        .TC     (TC),
        .CEO    (CEO),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gray(input int unsigned b);
        return gseq[b % 16];
    endfunction

    task automatic scramble();
        div    = 8'($urandom);
        mode   = 1'($urandom);
        cl     = 1'($urandom);
        nsteps = 4'($urandom);
    endtask

    // Leaves the bench just after the start edge, i.e. in RUN cycle 0.
    task automatic do_start(input logic md, input logic clr, input int unsigned dv,
                            input int unsigned ns);
        @(posedge clk); #1;
        mode = md; cl = clr; div = 8'(dv); nsteps = 4'(ns);
        start = 1'b1;
        stop  = 1'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
        scramble();
    endtask

    task automatic test_reset();
        rn = 1'b0; start = 1'b1; stop = 1'b0; div = 8'd5; mode = 1'b1; cl = 1'b1; nsteps = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (Y !== 4'b0000) begin n_bad++; $display("FAIL reset_y: got %b exp 0000", Y); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b exp 0", busy); end
        n_cmp++; if (ce_o !== 1'b0) begin n_bad++; $display("FAIL reset_ce: got %b exp 0", ce_o); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b exp 0", done); end
        n_cmp++; if (TC !== 1'b0 || CEO !== 1'b0) begin n_bad++; $display("FAIL reset_tc: got TC=%b CEO=%b exp 0 0", TC, CEO); end
        @(posedge clk); #1;
        rn = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_restart_busy: got %b exp 1", busy); end
        @(posedge clk); #1;
        stop = 1'b1;
        @(negedge clk);
        n_cmp++; if (ce_o !== 1'b0) begin n_bad++; $display("FAIL reset_stop_ce: got %b exp 0", ce_o); end
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || Y !== 4'b0000) begin n_bad++; $display("FAIL reset_stop_idle: got busy=%b Y=%b exp 0 0000", busy, Y); end
        m_b = 0;
    endtask

    task automatic test_oneshot(input int unsigned dv, input int unsigned ns, input logic clr);
        int unsigned n, r, b0, k;
        logic [3:0]  ey;
        logic        eb, ed, ec, et;
        n = (ns == 0) ? 16 : ns;
        r = n * (dv + 1);
        do_start(1'b0, clr, dv, ns);
        if (clr) m_b = 0;
        b0 = m_b;
        for (int unsigned t = 0; t <= r + 2; t++) begin
            @(negedge clk);
            eb = (t < r);
            ed = (t == r);
            ec = (t < r) && (((t + 1) % (dv + 1)) == 0);
            k  = (t < r) ? t / (dv + 1) : n;
            ey = gray(b0 + k);
            et = (ey == 4'b1000);
            n_cmp++; if (Y !== ey) begin n_bad++; $display("FAIL oneshot_y div=%0d n=%0d t=%0d: got %b exp %b", dv, n, t, Y, ey); end
            n_cmp++; if (busy !== eb) begin n_bad++; $display("FAIL oneshot_busy div=%0d n=%0d t=%0d: got %b exp %b", dv, n, t, busy, eb); end
            n_cmp++; if (done !== ed) begin n_bad++; $display("FAIL oneshot_done div=%0d n=%0d t=%0d: got %b exp %b", dv, n, t, done, ed); end
            n_cmp++; if (ce_o !== ec) begin n_bad++; $display("FAIL oneshot_ce div=%0d n=%0d t=%0d: got %b exp %b", dv, n, t, ce_o, ec); end
            n_cmp++; if (TC !== et) begin n_bad++; $display("FAIL oneshot_tc t=%0d: got %b exp %b", t, TC, et); end
            n_cmp++; if (CEO !== (ec && et)) begin n_bad++; $display("FAIL oneshot_ceo t=%0d: got %b exp %b", t, CEO, ec && et); end
            @(posedge clk); #1;
            scramble();
            // start is pulsed during DONE and must not launch a run.
            start = (t + 1 < r) ? 1'($urandom) : 1'(t + 1 == r);
        end
        start = 1'b0;
        m_b = (b0 + n) % 16;
    endtask

    task automatic test_continuous(input int unsigned dv, input logic clr, input int unsigned nc);
        int unsigned b0, k, ceo_exp, ceo_got;
        logic [3:0]  ey;
        logic        eb, ec, et;
        do_start(1'b1, clr, dv, $urandom % 16);
        if (clr) m_b = 0;
        b0 = m_b;
        ceo_exp = 0;
        ceo_got = 0;
        stop = (nc == 0);
        for (int unsigned t = 0; t <= nc + 1; t++) begin
            @(negedge clk);
            k  = ((t < nc) ? t : nc) / (dv + 1);
            eb = (t <= nc);
            ec = (t < nc) && (((t + 1) % (dv + 1)) == 0);
            ey = gray(b0 + k);
            et = (ey == 4'b1000);
            n_cmp++; if (Y !== ey) begin n_bad++; $display("FAIL cont_y div=%0d nc=%0d t=%0d: got %b exp %b", dv, nc, t, Y, ey); end
            n_cmp++; if (busy !== eb) begin n_bad++; $display("FAIL cont_busy div=%0d nc=%0d t=%0d: got %b exp %b", dv, nc, t, busy, eb); end
            n_cmp++; if (ce_o !== ec) begin n_bad++; $display("FAIL cont_ce div=%0d nc=%0d t=%0d: got %b exp %b", dv, nc, t, ce_o, ec); end
            n_cmp++; if (TC !== et) begin n_bad++; $display("FAIL cont_tc t=%0d: got %b exp %b", t, TC, et); end
            n_cmp++; if (CEO !== (ec && et)) begin n_bad++; $display("FAIL cont_ceo t=%0d: got %b exp %b", t, CEO, ec && et); end
            n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL cont_done t=%0d: got %b exp 0", t, done); end
            if (CEO === 1'b1) ceo_got++;
            if (ec && et) ceo_exp++;
            @(posedge clk); #1;
            scramble();
            stop  = (t + 1 == nc);
            start = (t + 1 <= nc) ? 1'($urandom) : 1'b0;
        end
        n_cmp++; if (ceo_got !== ceo_exp) begin n_bad++; $display("FAIL cont_ceo_count: got %0d exp %0d", ceo_got, ceo_exp); end
        m_b = (b0 + nc / (dv + 1)) % 16;
    endtask

    task automatic test_stop_collision();
        do_start(1'b1, 1'b1, 2, 0);
        m_b = 0;
        repeat (5) @(posedge clk);
        #1;
        stop = 1'b1;   // cycle 5: prescaler at 2, step would be due
        @(negedge clk);
        n_cmp++; if (ce_o !== 1'b0) begin n_bad++; $display("FAIL stopcol_ce: got %b exp 0", ce_o); end
        n_cmp++; if (Y !== 4'b0001) begin n_bad++; $display("FAIL stopcol_y: got %b exp 0001", Y); end
        @(posedge clk); #1;
        stop = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stopcol_busy: got %b exp 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL stopcol_done: got %b exp 0", done); end
        n_cmp++; if (Y !== 4'b0001) begin n_bad++; $display("FAIL stopcol_hold: got %b exp 0001", Y); end
        m_b = 1;
    endtask

    task automatic test_nsteps_zero();
        test_oneshot(1, 5, 1'b1);
        @(negedge clk);
        n_cmp++; if (Y !== 4'b0111) begin n_bad++; $display("FAIL nz_setup_y: got %b exp 0111", Y); end
        test_oneshot(0, 0, 1'b0);
        @(negedge clk);
        n_cmp++; if (Y !== 4'b0111) begin n_bad++; $display("FAIL nz_end_y: got %b exp 0111", Y); end
    endtask

    task automatic test_midrun_reset();
        do_start(1'b1, 1'b1, 1, 0);
        m_b = 0;
        @(posedge clk); #1;
        rn = 1'b0;     // cycle 1: step due at the closing edge
        @(posedge clk); #1;
        rn = 1'b1;
        @(negedge clk);
        n_cmp++; if (Y !== 4'b0000) begin n_bad++; $display("FAIL mrst_y: got %b exp 0000", Y); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b exp 0", busy); end
        n_cmp++; if (ce_o !== 1'b0) begin n_bad++; $display("FAIL mrst_ce: got %b exp 0", ce_o); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL mrst_done: got %b exp 0", done); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL mrst_after: got done=%b busy=%b exp 0 0", done, busy); end
        m_b = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            if (($urandom % 2) == 0)
                test_oneshot($urandom_range(0, 4), $urandom_range(0, 15), 1'($urandom));
            else
                test_continuous($urandom_range(0, 4), 1'($urandom), $urandom_range(0, 40));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        gseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        n_cmp = 0;
        n_bad = 0;
        m_b   = 0;
        rn = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0; cl = 1'b0; div = '0; nsteps = '0;
        test_reset();
        test_oneshot(3, 5, 1'b1);
        test_continuous(0, 1'b1, 16);
        test_stop_collision();
        test_nsteps_zero();
        test_midrun_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
